// File: rtl/ngc_counter_pkg.sv
// Shared types for the counter sequencer: FSM state encoding and the latched sweep command.
package ngc_counter_pkg;

    // Field widths of the latched command; sequencer parameters default to these.
    localparam int SEQ_COUNT_WIDTH = 8;
    localparam int SEQ_REPS_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic [SEQ_COUNT_WIDTH-1:0]   from;
        logic [SEQ_COUNT_WIDTH-1:0]   to;
        logic [SEQ_COUNT_WIDTH/2-1:0] step;
        logic                         dir;
        logic [SEQ_REPS_WIDTH-1:0]    reps;
    } seq_cmd_t;

endpackage

// File: rtl/ngc_counter_if.sv
// Control/status bundle between a counter master (sequencer) and the counter slave.
interface ngc_counter_if #(
    parameter int COUNT_WIDTH = 8
) (
    input logic clk
);
    logic                     rst;
    logic                     load;
    logic                     enb;
    logic                     dir;
    logic                     one_shot;
    logic [COUNT_WIDTH-1:0]   load_value;
    logic [COUNT_WIDTH-1:0]   count_from_value;
    logic [COUNT_WIDTH-1:0]   count_to_value;
    logic [COUNT_WIDTH/2-1:0] step_value;
    logic [COUNT_WIDTH-1:0]   count;
    logic                     count_hit;

    modport master_mp (
        input  clk, count_hit,
        output rst, load, enb, dir, one_shot,
               load_value, count_from_value, count_to_value, step_value
    );

    modport slave_mp (
        input  clk, rst, load, enb, dir, one_shot,
               load_value, count_from_value, count_to_value, step_value,
        output count, count_hit
    );
endinterface

// File: rtl/ngc_counter.sv
// Step counter slave: loads, counts up/down by step, flags and reloads on reaching the terminal value.
module ngc_counter #(
    parameter int COUNT_WIDTH = 8
) (
    ngc_counter_if.slave_mp ctr
);

    // Hit is flagged in the cycle the terminal value is present while enabled.
    assign ctr.count_hit = ctr.enb && (ctr.count == ctr.count_to_value);

    always_ff @(posedge ctr.clk) begin
        if (ctr.rst) begin
            ctr.count <= '0;
        end else if (ctr.load) begin
            ctr.count <= ctr.load_value;
        end else if (ctr.enb) begin
            if (ctr.count == ctr.count_to_value) begin
                if (!ctr.one_shot) begin
                    ctr.count <= ctr.count_from_value;
                end
            end else if (ctr.dir) begin
                ctr.count <= ctr.count + COUNT_WIDTH'(ctr.step_value);
            end else begin
                ctr.count <= ctr.count - COUNT_WIDTH'(ctr.step_value);
            end
        end
    end

endmodule

// File: rtl/ngc_counter_seq.sv
// Sweep sequencer driving an ngc_counter_if master; abort support is built when
// NGC_COUNTER_SEQ_ABORT_EN is defined.
module ngc_counter_seq
    import ngc_counter_pkg::*;
#(
    parameter int COUNT_WIDTH = SEQ_COUNT_WIDTH,
    parameter int REPS_WIDTH  = SEQ_REPS_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [COUNT_WIDTH-1:0]   cmd_from,
    input  logic [COUNT_WIDTH-1:0]   cmd_to,
    input  logic [COUNT_WIDTH/2-1:0] cmd_step,
    input  logic                     cmd_dir,
    input  logic [REPS_WIDTH-1:0]    cmd_reps,
`ifdef NGC_COUNTER_SEQ_ABORT_EN
    input  logic                     abort,
    output logic                     aborted,
`endif
    output logic                     busy,
    output logic                     done,
    output logic [REPS_WIDTH-1:0]    hit_count,
    ngc_counter_if.master_mp         ctr
);

    localparam int STEP_WIDTH = COUNT_WIDTH / 2;

    seq_state_t            state;
    seq_cmd_t              cmd;
    logic                  load_q;
    logic                  enb_q;
    logic [REPS_WIDTH-1:0] hits_next;
    logic [REPS_WIDTH-1:0] reps;
    logic                  final_hit;

    assign reps      = REPS_WIDTH'(cmd.reps);
    assign hits_next = hit_count + REPS_WIDTH'(1);
    assign final_hit = ctr.count_hit && (reps != '0) && (hits_next == reps);

`ifdef NGC_COUNTER_SEQ_ABORT_EN
    logic abort_pulse;
    logic abort_now;

    assign abort_now = abort && ((state == LOAD) || (state == RUN));
    assign ctr.rst   = rst | abort_pulse;
`else
    assign ctr.rst   = rst;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd       <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            hit_count <= '0;
            load_q    <= 1'b0;
            enb_q     <= 1'b0;
`ifdef NGC_COUNTER_SEQ_ABORT_EN
            aborted     <= 1'b0;
            abort_pulse <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef NGC_COUNTER_SEQ_ABORT_EN
            aborted     <= 1'b0;
            abort_pulse <= 1'b0;
            // Abort outranks a coincident final hit; hit_count is left as it was.
            if (abort_now) begin
                state       <= IDLE;
                cmd_ready   <= 1'b1;
                busy        <= 1'b0;
                load_q      <= 1'b0;
                enb_q       <= 1'b0;
                aborted     <= 1'b1;
                abort_pulse <= 1'b1;
            end else
`endif
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd.from  <= SEQ_COUNT_WIDTH'(cmd_from);
                        cmd.to    <= SEQ_COUNT_WIDTH'(cmd_to);
                        cmd.step  <= (SEQ_COUNT_WIDTH / 2)'(cmd_step);
                        cmd.dir   <= cmd_dir;
                        cmd.reps  <= SEQ_REPS_WIDTH'(cmd_reps);
                        hit_count <= '0;
                        state     <= LOAD;
                        load_q    <= 1'b1;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    load_q <= 1'b0;
                    enb_q  <= 1'b1;
                    state  <= RUN;
                end
                RUN: begin
                    if (ctr.count_hit) begin
                        hit_count <= hits_next;
                        if (final_hit) begin
                            state <= DONE;
                            enb_q <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    load_q    <= 1'b0;
                    enb_q     <= 1'b0;
                end
            endcase
        end
    end

    assign ctr.load             = load_q;
    assign ctr.enb              = enb_q;
    assign ctr.dir              = cmd.dir;
    assign ctr.one_shot         = 1'b0;
    assign ctr.load_value       = COUNT_WIDTH'(cmd.from);
    assign ctr.count_from_value = COUNT_WIDTH'(cmd.from);
    assign ctr.count_to_value   = COUNT_WIDTH'(cmd.to);
    assign ctr.step_value       = STEP_WIDTH'(cmd.step);

endmodule

// File: tb/tb_ngc_counter_seq.sv
// Directed bench: sequencer paired with the counter slave on one shared interface instance.
module tb_ngc_counter_seq;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_from;
    logic [7:0] cmd_to;
    logic [3:0] cmd_step;
    logic       cmd_dir;
    logic [7:0] cmd_reps;
    logic       busy;
    logic       done;
    logic [7:0] hit_count;
`ifdef NGC_COUNTER_SEQ_ABORT_EN
    logic       abort;
    logic       aborted;
`endif

    int checks   = 0;
    int failures = 0;

    ngc_counter_if #(.COUNT_WIDTH(8)) ctr_if (.clk(clk));

    ngc_counter_seq #(.COUNT_WIDTH(8), .REPS_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_from  (cmd_from),
        .cmd_to    (cmd_to),
        .cmd_step  (cmd_step),
        .cmd_dir   (cmd_dir),
        .cmd_reps  (cmd_reps),
`ifdef NGC_COUNTER_SEQ_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .busy      (busy),
        .done      (done),
        .hit_count (hit_count),
        .ctr       (ctr_if)
    );

    ngc_counter #(.COUNT_WIDTH(8)) slave (.ctr(ctr_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one command for a single cycle; returns sampled in cycle N+1.
    task automatic send(input logic [7:0] f, input logic [7:0] t, input logic [3:0] s,
                        input logic d, input logic [7:0] r);
        cmd_from  = f;
        cmd_to    = t;
        cmd_step  = s;
        cmd_dir   = d;
        cmd_reps  = r;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int hits;
        int dones;
        int done_cyc;
        int budget;
        int exp_seq[5];

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_from  = '0;
        cmd_to    = '0;
        cmd_step  = '0;
        cmd_dir   = 1'b0;
        cmd_reps  = '0;
`ifdef NGC_COUNTER_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        tick();
        tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_load", ctr_if.load, 0);
        chk("rst_enb", ctr_if.enb, 0);
        chk("rst_dir", ctr_if.dir, 0);
        chk("rst_load_value", ctr_if.load_value, 0);
        chk("rst_to_value", ctr_if.count_to_value, 0);
        chk("rst_step_value", ctr_if.step_value, 0);
        chk("rst_ctr_rst", ctr_if.rst, 1);
        rst = 1'b0;
        tick();

        // Up sweep 0..5 step 1, three hits: hits at N+7, N+13, N+19, done at N+20.
        send(8'd0, 8'd5, 4'd1, 1'b1, 8'd3);
        chk("up_load_n1", ctr_if.load, 1);
        chk("up_enb_n1", ctr_if.enb, 0);
        chk("up_ready_n1", cmd_ready, 0);
        chk("up_busy_n1", busy, 1);
        chk("up_to_value", ctr_if.count_to_value, 5);
        chk("up_dir", ctr_if.dir, 1);
        chk("up_one_shot", ctr_if.one_shot, 0);
        hits     = 0;
        dones    = 0;
        done_cyc = -1;
        for (int c = 2; c <= 40 && done_cyc < 0; c++) begin
            tick();
            if (c == 2) begin
                chk("up_enb_n2", ctr_if.enb, 1);
                chk("up_count_n2", ctr_if.count, 0);
            end
            if (ctr_if.count_hit) hits++;
            if (done) begin
                dones++;
                done_cyc = c;
            end
        end
        chk("up_done_cycle", done_cyc, 20);
        chk("up_hits_seen", hits, 3);
        chk("up_hit_count", hit_count, 3);
        chk("up_enb_in_done", ctr_if.enb, 0);
        tick();
        chk("up_done_pulse_end", done, 0);
        chk("up_ready_after", cmd_ready, 1);
        chk("up_busy_after", busy, 0);
        chk("up_done_once", dones, 1);

        // Down sweep 10..2 step 2, one hit.
        send(8'd10, 8'd2, 4'd2, 1'b0, 8'd1);
        exp_seq = '{10, 8, 6, 4, 2};
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("down_count_%0d", i), ctr_if.count, exp_seq[i]);
        end
        chk("down_hit", ctr_if.count_hit, 1);
        chk("down_no_early_done", done, 0);
        tick();
        chk("down_done", done, 1);
        chk("down_hit_count", hit_count, 1);
        tick();
        chk("down_done_end", done, 0);
        chk("down_ready", cmd_ready, 1);

        // Commands offered while busy must be neither accepted nor stored.
        send(8'd20, 8'd30, 4'd1, 1'b1, 8'd1);
        cmd_from  = 8'd99;
        cmd_to    = 8'd99;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("busy_load_value", ctr_if.load_value, 20);
        chk("busy_no_reload", ctr_if.load, 0);
        chk("busy_ready_low", cmd_ready, 0);
        cmd_valid = 1'b0;
        budget = 30;
        while (!done && budget > 0) begin
            tick();
            budget--;
        end
        chk("busy_done_seen", done, 1);
        chk("busy_load_value_end", ctr_if.load_value, 20);
        chk("busy_to_value_end", ctr_if.count_to_value, 30);
        tick();

        // Reset in RUN: count 0..3 repeating with reps=0, one hit by N+7.
        send(8'd0, 8'd3, 4'd1, 1'b1, 8'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("rstrun_hits_before", hit_count, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstrun_ready", cmd_ready, 1);
        chk("rstrun_busy", busy, 0);
        chk("rstrun_done", done, 0);
        chk("rstrun_hit_count", hit_count, 0);
        chk("rstrun_load", ctr_if.load, 0);
        chk("rstrun_enb", ctr_if.enb, 0);
        chk("rstrun_dir", ctr_if.dir, 0);
        chk("rstrun_load_value", ctr_if.load_value, 0);
        chk("rstrun_count", ctr_if.count, 0);
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) dones++;
`ifdef NGC_COUNTER_SEQ_ABORT_EN
            if (aborted) dones++;
`endif
        end
        chk("rstrun_no_pulses", dones, 0);

`ifdef NGC_COUNTER_SEQ_ABORT_EN
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_ignored", aborted, 0);
        chk("idle_abort_ready", cmd_ready, 1);
        chk("idle_abort_ctr_rst", ctr_if.rst, 0);

        // Abort after two hits of an endless 0..1 sweep.
        send(8'd0, 8'd1, 4'd1, 1'b1, 8'd0);
        hits   = 0;
        budget = 20;
        while (hits < 2 && budget > 0) begin
            tick();
            if (ctr_if.count_hit) hits++;
            budget--;
        end
        chk("abort_two_hits_seen", hits, 2);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_pulse", aborted, 1);
        chk("abort_ctr_rst", ctr_if.rst, 1);
        chk("abort_hit_count", hit_count, 2);
        chk("abort_no_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", cmd_ready, 1);
        tick();
        chk("abort_pulse_end", aborted, 0);
        chk("abort_ctr_rst_end", ctr_if.rst, 0);
        chk("abort_no_done_later", done, 0);

        // Abort coincident with the final hit of a reps=1 sweep.
        send(8'd0, 8'd2, 4'd1, 1'b1, 8'd1);
        budget = 20;
        while (!ctr_if.count_hit && budget > 0) begin
            tick();
            budget--;
        end
        chk("coll_hit_seen", ctr_if.count_hit, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("coll_aborted", aborted, 1);
        chk("coll_no_done", done, 0);
        chk("coll_hit_count", hit_count, 0);
        tick();
        chk("coll_no_done_later", done, 0);
        chk("coll_aborted_end", aborted, 0);
        chk("coll_ready", cmd_ready, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ngc_counter_seq.md
NGC_COUNTER_SEQ -- requirements
Module: ngc_counter_seq

Interface
REQ-001 Parameter: COUNT_WIDTH, default 8, is the counter width and must match the width of the attached ngc_counter_if.
REQ-002 Parameter: REPS_WIDTH, default 8, is the width of the repetition count and hit counter.
REQ-003 clk  in  1  sole clock; all logic on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid  in  1  sweep command offered.
REQ-006 cmd_ready  out  1  sequencer can accept a command.
REQ-007 cmd_from  in  COUNT_WIDTH  start and reload value.
REQ-008 cmd_to  in  COUNT_WIDTH  terminal value.
REQ-009 cmd_step  in  COUNT_WIDTH/2  increment magnitude.
REQ-010 cmd_dir  in  1  count direction: 1 = up, 0 = down.
REQ-011 cmd_reps  in  REPS_WIDTH  number of count_hit events before done; 0 = run until abort.
REQ-012 abort  in  1  terminate the active sweep (only present when ABORT is enabled, see Configuration).
REQ-013 busy  out  1  a sweep is in progress.
REQ-014 done  out  1  one-cycle pulse when the sweep completes.
REQ-015 aborted  out  1  one-cycle pulse when the sweep is aborted (only present when ABORT is enabled).
REQ-016 hit_count  out  REPS_WIDTH  number of count_hit events in the current or last sweep.
REQ-017 ctr  ngc_counter_if.master_mp  --  drives the counter; ctr.clk is not driven, because the interface instance shares clk.

Function
REQ-018 States: IDLE, LOAD, RUN, DONE; the transition rules are REQ-019 to REQ-022.
REQ-019 IDLE: cmd_ready=1; when cmd_valid&&cmd_ready, latch all cmd_* fields, clear hit_count, and go to LOAD.
REQ-020 LOAD (1 cycle): ctr.load=1, ctr.enb=0; go to RUN.
REQ-021 RUN: ctr.enb=1; each cycle with ctr.count_hit=1 increments hit_count (wraps at 2^REPS_WIDTH); a hit that makes hit_count equal to a nonzero cmd_reps goes to DONE.
REQ-022 DONE (1 cycle): done=1, ctr.enb=0; go to IDLE.
REQ-023 ctr.load_value=cmd_from and ctr.count_from_value=cmd_from, from the latched values.
REQ-024 ctr.count_to_value, ctr.step_value and ctr.dir are the latched cmd_to, cmd_step and cmd_dir, held stable from LOAD until the next accept.
REQ-025 ctr.one_shot=0 in all states.
REQ-026 cmd_ready=0 and busy=1 in LOAD, RUN and DONE; commands offered then are not accepted and not stored.
REQ-027 Latency: accept in cycle N → ctr.load=1 in N+1 → ctr.enb=1 from N+2; final hit in cycle M → done=1 in M+1, cmd_ready=1 in M+2.
REQ-028 count_hit observed outside RUN is ignored.
REQ-029 ctr.rst = rst OR abort_pulse, where abort_pulse is a registered one-cycle pulse.

Reset
REQ-030 rst → next state IDLE; cmd_ready=1, busy=0, done=0, aborted=0, hit_count=0.
REQ-031 rst → ctr.load=0, ctr.enb=0, ctr.dir=0, and all ctr.*_value outputs=0.
REQ-032 rst mid-sweep discards the sweep, with no done or aborted pulse.

Configuration
REQ-033 Macro NGC_COUNTER_SEQ_ABORT_EN defined: the abort input and aborted output exist.
REQ-034 With the macro defined, abort=1 in LOAD or RUN → next cycle IDLE, aborted=1 for 1 cycle, ctr.rst=1 for 1 cycle, hit_count held.
REQ-035 abort in IDLE or DONE has no effect.
REQ-036 abort and the final hit in the same cycle → abort wins: aborted pulses and done does not.
REQ-037 Macro NGC_COUNTER_SEQ_ABORT_EN undefined: the abort and aborted ports are absent, and a cmd_reps=0 sweep ends only on rst.

Structure
REQ-038 Package ngc_counter_pkg holds typedef seq_state_t (the enum of REQ-018) and typedef seq_cmd_t (a struct of from, to, step, dir, reps).
REQ-039 No sub-module; the counter slave is a separate instance connected via ngc_counter_if.

Verification
REQ-040 Bench pairs the sequencer with a counter slave on one ngc_counter_if.
REQ-041 Up sweep: from=0, to=5, step=1, dir=1, reps=3 → ctr.load=1 in N+1, exactly 3 count_hit events counted, hit_count=3, done pulses once, then cmd_ready=1.
REQ-042 Down sweep: from=10, to=2, step=2, dir=0, reps=1 → count sequence 10, 8, 6, 4, 2; done 1 cycle after the hit.
REQ-043 Busy rejection: cmd_valid=1 held during RUN with from=99 → not accepted; ctr.load_value stays at the original value.
REQ-044 Abort (macro defined): reps=0, abort after 2 hits → aborted=1 for 1 cycle, ctr.rst=1 for 1 cycle, hit_count=2, no done.
REQ-045 Collision: abort in the same cycle as the final hit with reps=1 → aborted=1, done=0.
REQ-046 Reset mid-RUN: rst=1 for 1 cycle → all outputs at reset values next cycle, and no pulses.
